// File: rtl/sipo_frame_ctrl.sv
// Frame controller for an external WIDTH-bit SIPO shift register: gates shifting,
// counts bits per frame and buffers each completed word behind a valid/ready handshake.
module sipo_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             RSTN,
  input  logic             BIT_STB,
  input  logic             SYNC,
  output logic             SH_EN,
  input  logic [WIDTH-1:0] PI,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             OVR,
  input  logic             OVR_CLR,
  output logic [7:0]       FRM_CNT
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_sh_en;
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic             r_ovr;
  logic [7:0]       r_frm_cnt;
  logic             w_load;
  logic             w_drop;

  always_ff @(posedge C or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_en     = 1'b0;
    case (r_state)
      IDLE: begin
        w_sh_en = BIT_STB & SYNC;
        if (BIT_STB && SYNC) begin
          w_cnt_nxt   = CW'(1);
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        w_sh_en = BIT_STB;
        if (BIT_STB && SYNC) begin
          w_cnt_nxt = CW'(1);
        end else if (BIT_STB) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_state_nxt = CAPT;
          end
        end
      end
      CAPT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A full buffer can still take the new word if the consumer drains it at this edge.
  assign w_load = (r_state == CAPT) && (!r_dvalid || DREADY);
  assign w_drop = (r_state == CAPT) && r_dvalid && !DREADY;

  always_ff @(posedge C or negedge RSTN) begin
    if (!RSTN) begin
      r_dout    <= '0;
      r_dvalid  <= 1'b0;
      r_ovr     <= 1'b0;
      r_frm_cnt <= 8'd0;
    end else begin
      if (w_load) begin
        r_dout    <= PI;
        r_dvalid  <= 1'b1;
        r_frm_cnt <= r_frm_cnt + 8'd1;
      end else if (r_dvalid && DREADY) begin
        r_dvalid  <= 1'b0;
      end
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (OVR_CLR) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign SH_EN   = w_sh_en & RSTN;
  assign DOUT    = r_dout;
  assign DVALID  = r_dvalid;
  assign OVR     = r_ovr;
  assign FRM_CNT = r_frm_cnt;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed, table-driven bench for sipo_frame_ctrl: one vector per clock cycle,
// plus a hand-written asynchronous reset sequence in the middle of a frame.
module tb_sipo_frame_ctrl;

  logic       C;
  logic       RSTN;
  logic       BIT_STB;
  logic       SYNC;
  logic       SH_EN;
  logic [7:0] PI;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       DREADY;
  logic       OVR;
  logic       OVR_CLR;
  logic [7:0] FRM_CNT;

  int checks = 0;
  int errors = 0;

  sipo_frame_ctrl #(.WIDTH(8)) dut (
    .C       (C),
    .RSTN    (RSTN),
    .BIT_STB (BIT_STB),
    .SYNC    (SYNC),
    .SH_EN   (SH_EN),
    .PI      (PI),
    .DOUT    (DOUT),
    .DVALID  (DVALID),
    .DREADY  (DREADY),
    .OVR     (OVR),
    .OVR_CLR (OVR_CLR),
    .FRM_CNT (FRM_CNT)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  typedef struct {
    logic       stb;
    logic       sync;
    logic [7:0] pi;
    logic       rdy;
    logic       clr;
    logic       expSh;
    logic       expV;
    logic [7:0] expD;
    logic       expO;
    logic [7:0] expF;
  } vec_t;

  vec_t vecs[$];

  logic       expV = 1'b0;
  logic [7:0] expD = 8'h00;
  logic       expO = 1'b0;
  logic [7:0] expF = 8'h00;

  task automatic vec(input logic stb, input logic sync, input logic [7:0] pi,
                     input logic rdy, input logic clr, input logic sh);
    vec_t v;
    v.stb = stb; v.sync = sync; v.pi = pi; v.rdy = rdy; v.clr = clr;
    v.expSh = sh; v.expV = expV; v.expD = expD; v.expO = expO; v.expF = expF;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic stb, input logic sync, input logic [7:0] pi,
                               input logic rdy, input logic clr);
    BIT_STB = stb;
    SYNC    = sync;
    PI      = pi;
    DREADY  = rdy;
    OVR_CLR = clr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic sh, input logic v,
                          input logic [7:0] d, input logic o, input logic [7:0] f);
    checkOutput({tag, " SH_EN"}, 32'(SH_EN), 32'(sh));
    checkOutput({tag, " DVALID"}, 32'(DVALID), 32'(v));
    checkOutput({tag, " DOUT"}, 32'(DOUT), 32'(d));
    checkOutput({tag, " OVR"}, 32'(OVR), 32'(o));
    checkOutput({tag, " FRM_CNT"}, 32'(FRM_CNT), 32'(f));
  endtask

  initial begin
    // Frame 1: A5 captured with DREADY low.
    vec(1, 1, 8'h00, 0, 0, 1);
    repeat (7) vec(1, 0, 8'h00, 0, 0, 1);
    vec(0, 0, 8'hA5, 0, 0, 0);
    expV = 1; expD = 8'hA5; expF = 8'd1;
    // Strobes without SYNC in IDLE are ignored.
    vec(1, 0, 8'hA5, 0, 0, 0);
    vec(1, 0, 8'hA5, 0, 0, 0);
    vec(0, 0, 8'hA5, 0, 0, 0);
    // Frame 2 (with an idle gap) overruns the full buffer.
    vec(1, 1, 8'h00, 0, 0, 1);
    vec(0, 0, 8'h00, 0, 0, 0);
    repeat (7) vec(1, 0, 8'h00, 0, 0, 1);
    vec(0, 0, 8'h3C, 0, 0, 0);
    expO = 1;
    vec(0, 0, 8'h3C, 0, 1, 0);
    expO = 0;
    vec(0, 0, 8'h3C, 0, 0, 0);
    // Frame 3 overruns in the same cycle as OVR_CLR: set wins.
    vec(1, 1, 8'h00, 0, 0, 1);
    repeat (7) vec(1, 0, 8'h00, 0, 0, 1);
    vec(0, 0, 8'h3C, 0, 1, 0);
    expO = 1;
    vec(0, 0, 8'h00, 0, 1, 0);
    expO = 0;
    // Frame 4: capture with DREADY high while full; SYNC strobe in CAPT ignored.
    vec(1, 1, 8'h00, 0, 0, 1);
    repeat (7) vec(1, 0, 8'h00, 0, 0, 1);
    vec(1, 1, 8'h5A, 1, 0, 0);
    expD = 8'h5A; expF = 8'd2;
    vec(1, 0, 8'h5A, 0, 0, 0);
    vec(0, 0, 8'h5A, 1, 0, 0);
    expV = 0;
    vec(0, 0, 8'h5A, 0, 0, 0);
    // Resync after 5 bits: only the 8 bits after the resync make a frame.
    vec(1, 1, 8'h00, 0, 0, 1);
    repeat (4) vec(1, 0, 8'h00, 0, 0, 1);
    vec(1, 1, 8'h00, 0, 0, 1);
    repeat (7) vec(1, 0, 8'h00, 0, 0, 1);
    vec(0, 0, 8'hC3, 0, 0, 0);
    expV = 1; expD = 8'hC3; expF = 8'd3;
    vec(0, 0, 8'hC3, 0, 0, 0);
    vec(0, 0, 8'hC3, 0, 0, 0);

    RSTN = 1'b0;
    applyStimulus(1, 1, 8'h00, 0, 0);
    #2;
    checkAll("reset", 0, 0, 8'h00, 0, 8'h00);
    @(negedge C);
    RSTN = 1'b1;
    applyStimulus(0, 0, 8'h00, 0, 0);
    @(posedge C);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stb, vecs[i].sync, vecs[i].pi, vecs[i].rdy, vecs[i].clr);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].expSh, vecs[i].expV, vecs[i].expD,
               vecs[i].expO, vecs[i].expF);
      @(posedge C);
      #1;
    end

    // Reset asserted during bit 4 of a frame.
    applyStimulus(1, 1, 8'h00, 0, 0);
    @(posedge C);
    #1;
    repeat (3) begin
      applyStimulus(1, 0, 8'h00, 0, 0);
      @(posedge C);
      #1;
    end
    applyStimulus(1, 0, 8'h00, 0, 0);
    #2;
    RSTN = 1'b0;
    #1;
    checkAll("midReset", 0, 0, 8'h00, 0, 8'h00);
    @(posedge C);
    @(negedge C);
    RSTN = 1'b1;
    @(posedge C);
    #1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 8'hFF, 0, 0);
      #1;
      checkOutput($sformatf("postReset%0d SH_EN", i), 32'(SH_EN), 32'd0);
      @(posedge C);
      #1;
    end
    applyStimulus(0, 0, 8'hFF, 0, 0);
    repeat (3) @(posedge C);
    #1;
    checkAll("postReset", 0, 0, 8'h00, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Frame controller that sequences an external WIDTH-bit serial-in/parallel-out shift register.
- Gates the shift register's shift enable from a bit strobe and a frame sync, and counts bits per frame.
- On frame completion, captures the register's parallel output into a one-deep output buffer drained by a valid/ready handshake.
- Sits between the serial line front end and the word-level consumer.

Parameters:
- WIDTH, 8, bits per frame and the width of the shift register, PI and DOUT. Legal range 2..32.

Ports:
- C  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- BIT_STB  in  1  one-cycle strobe: the serial bit on the shift register's SI is valid this cycle.
- SYNC  in  1  frame start; meaningful only when BIT_STB=1. Marks the current bit as bit 1 of a frame.
- SH_EN  out  1  shift enable to the shift register; combinational.
- PI  in  WIDTH  parallel output of the shift register.
- DOUT  out  WIDTH  captured word.
- DVALID  out  1  DOUT holds an unconsumed word.
- DREADY  in  1  consumer accepts DOUT when DVALID&DREADY.
- OVR  out  1  sticky overrun: a completed frame was dropped because the buffer was full.
- OVR_CLR  in  1  synchronous clear of OVR.
- FRM_CNT  out  8  count of frames accepted into the buffer; wraps 255->0.

Behaviour:
- Reset (RSTN=0, asynchronous): state=IDLE, bit count=0, DOUT=0, DVALID=0, OVR=0, FRM_CNT=0. SH_EN=0 while in reset.
- States: IDLE, RECV, CAPT.
- IDLE:
  - SH_EN = BIT_STB & SYNC.
  - On BIT_STB&SYNC: count<=1, go to RECV.
  - BIT_STB without SYNC is ignored (no shift).
- RECV:
  - SH_EN = BIT_STB.
  - On BIT_STB&SYNC: resync; count<=1, stay in RECV. The partial frame is discarded silently.
  - On BIT_STB without SYNC: count<=count+1. If count was WIDTH-1, go to CAPT.
  - Cycles without BIT_STB: hold.
- CAPT (exactly one cycle; PI now holds the full frame):
  - SH_EN=0. Any BIT_STB this cycle is ignored, including one with SYNC.
  - If DVALID=0 or DREADY=1: DOUT<=PI, DVALID<=1, FRM_CNT<=FRM_CNT+1.
  - Otherwise the word is dropped and OVR<=1; DOUT, DVALID and FRM_CNT are unchanged.
  - Next state is IDLE.
- Latency: the last bit strobe (cycle N) moves the FSM to CAPT at the edge ending cycle N. Capture happens at the edge ending cycle N+1, so DVALID is high from cycle N+2.
- Minimum frame spacing: the next SYNC is accepted from cycle N+2 (IDLE).
- Handshake:
  - DVALID clears at an edge where DVALID&DREADY, unless the same edge loads a new word (CAPT with DREADY=1), in which case DVALID stays 1 and DOUT takes the new word.
  - DOUT is stable while DVALID=1 and DREADY=0.
- OVR:
  - OVR_CLR=1 clears OVR.
  - If OVR_CLR and a new overrun coincide at the same edge, the set wins (OVR=1).
- Count widths:
  - Bit count is clog2(WIDTH+1) bits and never exceeds WIDTH.
  - FRM_CNT is modulo 256.
- Reset mid-frame: the partial frame is abandoned and all outputs are at reset values. The external shift register contents are not this block's concern.

Test Plan:
- Reset, then SYNC+BIT_STB followed by 7 BIT_STB one cycle apart, with the shift register holding PI=8'hA5 after the 8th shift, DREADY=0 -> SH_EN high on each strobe only; DVALID=1 two cycles after the 8th strobe; DOUT=8'hA5; FRM_CNT=1; OVR=0.
- BIT_STB pulses with SYNC=0 while IDLE -> SH_EN stays 0; state, DVALID and FRM_CNT unchanged.
- Second frame (PI=8'h3C) completes while DVALID=1 and DREADY=0 -> DOUT remains 8'hA5, OVR=1, FRM_CNT=1. OVR_CLR pulse -> OVR=0. OVR_CLR coincident with another overrun -> OVR=1.
- Frame completes while DVALID=1 and DREADY=1 in the CAPT cycle -> DVALID stays 1, DOUT becomes the new PI, FRM_CNT increments, OVR=0.
- SYNC+BIT_STB after 5 bits of a frame -> count restarts. The frame completes only 7 strobes after the resync; exactly one capture occurs.
- RSTN pulled low for one cycle mid-RECV (bit 4) -> DVALID, OVR, FRM_CNT, DOUT=0 immediately. Subsequent strobes without SYNC are ignored.
